// File: rtl/muldiv_unit_if.sv
// Handshake and operand bundle between the issue logic and muldiv_unit.
interface muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            kill;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [4:0]      rd_in;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_out;
    logic            busy;

    modport master (
        output kill, in_valid, funct3, rs1_val, rs2_val, rd_in, out_ready,
        input  in_ready, out_valid, result, rd_out, busy
    );

    modport slave (
        input  kill, in_valid, funct3, rs1_val, rs2_val, rd_in, out_ready,
        output in_ready, out_valid, result, rd_out, busy
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide on operand magnitudes, sign fixed up in a final cycle.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input logic         clk,
    input logic         rst_n,
    muldiv_unit_if.slave bus
);
    localparam int CW = $clog2(XLEN);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;
    localparam logic [XLEN-1:0] MINV = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]      state;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] acc_hi;   // product high half / partial remainder
    logic [XLEN-1:0] acc_lo;   // multiplier (shifts out) / dividend -> quotient
    logic [XLEN-1:0] opnd;     // multiplicand or divisor magnitude
    logic [XLEN-1:0] res_q;
    logic [2:0]      op;
    logic [4:0]      rd_q;
    logic            neg_main; // negate product or quotient
    logic            neg_rem;  // negate remainder (dividend sign)

    logic            accept;
    logic            sgn1, sgn2, neg1, neg2;
    logic [XLEN-1:0] mag1, mag2;
    logic            is_div, div_zero, div_ovf;
    logic [XLEN-1:0] spec_res;
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shift, div_trial;
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0] quo_s, rem_s, fix_res;

    assign bus.in_ready  = (state == IDLE) && !bus.kill;
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.result    = res_q;
    assign bus.rd_out    = rd_q;
    assign accept        = bus.in_valid && bus.in_ready;

    // Decode operand signedness and magnitudes, and detect the one-cycle divide cases.
    always_comb begin
        sgn1 = 1'b0;
        sgn2 = 1'b0;
        case (bus.funct3)
            3'b001, 3'b100, 3'b110: begin sgn1 = 1'b1; sgn2 = 1'b1; end
            3'b010:                 begin sgn1 = 1'b1; sgn2 = 1'b0; end
            default:                begin sgn1 = 1'b0; sgn2 = 1'b0; end
        endcase
        neg1     = sgn1 && bus.rs1_val[XLEN-1];
        neg2     = sgn2 && bus.rs2_val[XLEN-1];
        mag1     = neg1 ? -bus.rs1_val : bus.rs1_val;
        mag2     = neg2 ? -bus.rs2_val : bus.rs2_val;
        is_div   = bus.funct3[2];
        div_zero = is_div && (bus.rs2_val == '0);
        div_ovf  = is_div && !bus.funct3[0] && (bus.rs1_val == MINV) && (bus.rs2_val == '1);
        if (div_zero)
            spec_res = bus.funct3[1] ? bus.rs1_val : '1;
        else
            spec_res = bus.funct3[1] ? '0 : MINV;
    end

    // One radix-2 step for both multiply and restoring divide.
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        div_shift = {acc_hi, acc_lo[XLEN-1]};
        div_trial = div_shift - {1'b0, opnd};
    end

    // Sign correction and result selection for the FIX cycle.
    always_comb begin
        prod   = {acc_hi, acc_lo};
        prod_s = neg_main ? -prod : prod;
        quo_s  = neg_main ? -acc_lo : acc_lo;
        rem_s  = neg_rem ? -acc_hi : acc_hi;
        case (op)
            3'b000:                 fix_res = prod_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_res = prod_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_res = quo_s;
            default:                fix_res = rem_s;
        endcase
    end

    // Sequencer and datapath registers; kill drops any non-idle operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opnd     <= '0;
            res_q    <= '0;
            op       <= '0;
            rd_q     <= '0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
        end else if (bus.kill && (state != IDLE)) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op       <= bus.funct3;
                        rd_q     <= bus.rd_in;
                        cnt      <= '0;
                        acc_hi   <= '0;
                        neg_main <= neg1 ^ neg2;
                        neg_rem  <= neg1;
                        if (is_div) begin
                            acc_lo <= mag1;
                            opnd   <= mag2;
                        end else begin
                            acc_lo <= mag2;
                            opnd   <= mag1;
                        end
                        if (div_zero || div_ovf) begin
                            res_q <= spec_res;
                            state <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (op[2]) begin
                        acc_hi <= div_trial[XLEN] ? div_shift[XLEN-1:0] : div_trial[XLEN-1:0];
                        acc_lo <= {acc_lo[XLEN-2:0], !div_trial[XLEN]};
                    end else begin
                        acc_hi <= mul_sum[XLEN:1];
                        acc_lo <= {mul_sum[0], acc_lo[XLEN-1:1]};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(XLEN - 1))
                        state <= FIX;
                end
                FIX: begin
                    res_q <= fix_res;
                    state <= DONE;
                end
                default: begin
                    if (bus.out_ready)
                        state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed table, corner sequences, random ops.
module tb_muldiv_unit;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;
    int   wr_cnt;

    muldiv_unit_if #(.XLEN(32)) bus ();
    muldiv_unit #(.XLEN(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count write-back strobes seen by the register file.
    always @(posedge clk) if (bus.out_valid && bus.out_ready) wr_cnt++;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        int          lat;
        int          hold;
    } vec_t;

    vec_t tbl[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ub;
        logic [63:0] p;
        logic ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ub  = longint'({32'h0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && b == 0) return 0;
        if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
        return 33;
    endfunction

    // Issue one operation, measure edges from accept to out_valid, optionally stall, then consume.
    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input int hold,
                         output logic [31:0] res, output logic [4:0] rdo, output int lat);
        int n;
        @(negedge clk);
        n = 0;
        while (!bus.in_ready && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) check("in_ready_wait", 0, 1);
        bus.in_valid  = 1'b1;
        bus.funct3    = f;
        bus.rs1_val   = a;
        bus.rs2_val   = b;
        bus.rd_in     = rd;
        bus.out_ready = (hold == 0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.rs1_val  = $urandom;
        bus.rs2_val  = $urandom;
        bus.funct3   = 3'($urandom);
        bus.rd_in    = 5'($urandom);
        lat = 0;
        while (!bus.out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        res = bus.result;
        rdo = bus.rd_out;
        check("in_ready_at_valid", bus.in_ready, 0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("hold_valid", bus.out_valid, 1);
            check("hold_result", bus.result, res);
            check("hold_rd", bus.rd_out, rdo);
            check("hold_in_ready", bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("consumed", bus.out_valid, 0);
        check("in_ready_after", bus.in_ready, 1);
    endtask

    initial begin
        logic [31:0] res, a, b;
        logic [4:0]  rdo, rd;
        logic [2:0]  f;
        int          lat, seen, w0;

        n_cmp  = 0;
        n_fail = 0;
        wr_cnt = 0;
        bus.kill = 1'b0; bus.in_valid = 1'b0; bus.funct3 = '0;
        bus.rs1_val = '0; bus.rs2_val = '0; bus.rd_in = '0; bus.out_ready = 1'b0;

        tbl[0]  = '{3'd0, 32'd7,          32'd6,          5'd5,  32'd42,         33, 0};
        tbl[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000,  5'd1,  32'h4000_0000,  33, 0};
        tbl[2]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd2,  32'hFFFF_FFFE,  33, 0};
        tbl[3]  = '{3'd2, 32'hFFFF_FFFF,  32'h0000_0002,  5'd3,  32'hFFFF_FFFF,  33, 0};
        tbl[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,          5'd4,  32'hFFFF_FFFD,  33, 0};
        tbl[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,          5'd6,  32'hFFFF_FFFF,  33, 0};
        tbl[6]  = '{3'd5, 32'hFFFF_FFF9,  32'd2,          5'd7,  32'h7FFF_FFFC,  33, 0};
        tbl[7]  = '{3'd5, 32'd5,          32'd0,          5'd8,  32'hFFFF_FFFF,  0,  0};
        tbl[8]  = '{3'd7, 32'd5,          32'd0,          5'd9,  32'd5,          0,  0};
        tbl[9]  = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  5'd10, 32'h8000_0000,  0,  0};
        tbl[10] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF,  5'd11, 32'h0,          0,  0};
        tbl[11] = '{3'd0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd0,  32'd1,          33, 0};
        tbl[12] = '{3'd5, 32'd100,        32'd7,          5'd31, 32'd14,         33, 5};

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_result", bus.result, 0);
        check("rst_rd_out", bus.rd_out, 0);
        check("rst_busy", bus.busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("idle_in_ready", bus.in_ready, 1);

        for (int i = 0; i < 13; i++) begin
            do_op(tbl[i].f, tbl[i].a, tbl[i].b, tbl[i].rd, tbl[i].hold, res, rdo, lat);
            check($sformatf("tbl%0d_result", i), res, tbl[i].exp);
            check($sformatf("tbl%0d_rd", i), rdo, tbl[i].rd);
            check($sformatf("tbl%0d_latency", i), lat, tbl[i].lat);
        end

        // Reset pulse at cycle 10 of CALC: operation vanishes, next op is normal.
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.funct3 = 3'd0; bus.rs1_val = 32'd9; bus.rs2_val = 32'd9; bus.rd_in = 5'd12;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy", bus.busy, 0);
        check("rst_mid_rd", bus.rd_out, 0);
        #2 rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen++;
        end
        check("rst_mid_no_valid", seen, 0);
        do_op(3'd0, 32'd3, 32'd4, 5'd13, 0, res, rdo, lat);
        check("post_rst_result", res, 12);
        check("post_rst_latency", lat, 33);

        // kill during DONE with out_ready low: result dropped, no write strobe.
        w0 = wr_cnt;
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.funct3 = 3'd3; bus.rs1_val = 32'd9; bus.rs2_val = 32'd9; bus.rd_in = 5'd14;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        check("kill_done_reached", bus.out_valid, 1);
        @(negedge clk);
        bus.kill = 1'b1;
        @(posedge clk);
        #1;
        check("kill_done_valid", bus.out_valid, 0);
        check("kill_done_busy", bus.busy, 0);
        bus.kill = 1'b0;
        check("kill_done_no_write", wr_cnt - w0, 0);

        // kill with in_valid in IDLE: not accepted.
        @(negedge clk);
        bus.kill = 1'b1; bus.in_valid = 1'b1;
        #1 check("kill_idle_in_ready", bus.in_ready, 0);
        @(posedge clk);
        #1;
        check("kill_idle_busy", bus.busy, 0);
        bus.kill = 1'b0; bus.in_valid = 1'b0;

        // kill during CALC: never completes.
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.funct3 = 3'd4; bus.rs1_val = 32'd50; bus.rs2_val = 32'd3;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        bus.kill = 1'b1;
        @(posedge clk);
        #1 bus.kill = 1'b0;
        check("kill_calc_busy", bus.busy, 0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen++;
        end
        check("kill_calc_no_valid", seen, 0);

        // Randomized operations against the arithmetic reference model.
        for (int i = 0; i < 40; i++) begin
            f  = 3'($urandom);
            a  = $urandom;
            b  = $urandom;
            rd = 5'($urandom);
            case ($urandom_range(0, 15))
                0, 1: b = 32'h0;
                2:    begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                3, 4: begin a = $urandom_range(0, 1000); b = $urandom_range(1, 20); end
                5:    b = -($urandom_range(1, 9));
                default: ;
            endcase
            do_op(f, a, b, rd, $urandom_range(0, 2), res, rdo, lat);
            check($sformatf("rnd%0d_f%0d_result", i, f), res, model(f, a, b));
            check($sformatf("rnd%0d_rd", i), rdo, rd);
            check($sformatf("rnd%0d_latency", i), lat, model_lat(f, a, b));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the execute stage, directly downstream of `registers` read ports.
- Consumes `rd1`/`rd2` operand values plus the destination index.
- Produces a result and destination index for the write-back path; write-back drives `a3`/`wd3`/`we3` with `we3 = out_valid & out_ready`.
- One operation in flight at a time; valid/ready handshakes on input and output.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported and verified.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- kill  input  1  synchronous abort of any in-flight or pending operation (pipeline flush).
- in_valid  input  1  operation request.
- in_ready  output  1  unit can accept; equals state==IDLE & !kill.
- funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1_val  input  XLEN  operand 1 (register file rd1).
- rs2_val  input  XLEN  operand 2 (register file rd2).
- rd_in  input  5  destination register index.
- out_valid  output  1  result available.
- out_ready  input  1  write-back accepts the result.
- result  output  XLEN  operation result.
- rd_out  output  5  destination index captured at accept.
- busy  output  1  state != IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - out_valid=0, result=0, rd_out=0, busy=0.
  - The internal counter and accumulators are cleared.
  - Reset mid-operation discards the operation; no result is ever presented.
- Accept:
  - A handshake occurs on the edge where in_valid & in_ready.
  - funct3, operands and rd_in are latched at that edge.
  - Later input changes are ignored until the unit returns to IDLE.
- States: IDLE, CALC, FIX, DONE.
  - IDLE -> CALC on accept (normal case). Counter cleared; operand magnitudes latched, with sign flags derived per funct3 (MULHSU: rs1 signed, rs2 unsigned).
  - CALC: one radix-2 step per cycle (shift-add multiply into a 64-bit product; restoring divide producing quotient and remainder). Exactly 32 cycles, then -> FIX.
  - FIX: apply sign correction and select the result; -> DONE.
  - DONE: out_valid=1; result and rd_out held stable while out_ready=0. On out_valid & out_ready -> IDLE.
- Latency: for an accept at edge N, out_valid rises after edge N+33.
- Special cases (IDLE -> DONE directly; out_valid after edge N):
  - Divide by zero: DIV/DIVU give 0xFFFFFFFF; REM/REMU give rs1_val.
  - Signed overflow (DIV/REM with rs1=0x80000000, rs2=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- Result selection:
  - MUL: low 32 bits of the product.
  - MULH/MULHSU/MULHU: high 32 bits of the correctly signed 64-bit product.
  - DIV: quotient truncated toward zero.
  - REM: remainder takes the sign of the dividend.
- No overlap: in_ready=0 in CALC, FIX and DONE, including the cycle the result is consumed. A new accept is possible from the next cycle.
- kill:
  - In any non-IDLE state, the next edge goes to IDLE with out_valid=0; the result is dropped.
  - kill together with in_valid in IDLE: no accept, because in_ready is 0.
- rd_in=0 is executed normally; the register file discards the write.
- out_valid only falls on an output handshake, kill or reset.

Test Plan:
- Reset, then MUL rs1=7 rs2=6 rd=5, out_ready=1 -> out_valid rises after edge N+33; result=42, rd_out=5; in_ready returns to 1 one cycle later.
- High-half products:
  - MULH 0x80000000×0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×0x00000002 -> 0xFFFFFFFF.
- Signed divide:
  - DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD.
  - REM -7 % 2 -> 0xFFFFFFFF.
  - DIVU 0xFFFFFFF9 / 2 -> 0x7FFFFFFC.
- Special cases:
  - DIVU 5/0 -> 0xFFFFFFFF after one cycle.
  - REMU 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
  - REM of the same operands -> 0.
  - All four take one-cycle latency.
- Backpressure: out_ready held 0 for 5 cycles after out_valid -> result, rd_out and out_valid stable; in_ready=0 throughout; consumed on the first out_ready=1 edge.
- Abort paths:
  - rst_n pulsed low during CALC (cycle 10) -> out_valid never asserts; next MUL 3×4 gives 12 with normal latency.
  - kill during DONE -> out_valid drops next edge and no write occurs.
